alu_sequencer: RTL and testbench
================================

# alu_sequencer

Instruction sequencer that drives the combinational ALU from the initiator side. It fetches 32-bit instruction words from a synchronous program memory and reads operands from an internal 16x16 register file. It presents opcode/A/B to the ALU, writes the ALU result back to the register file and holds the architectural flags. It sits between program memory and the ALU as the processor's control core.

## Interface
- DATA_WIDTH, 16, register, ALU operand and result width.
- PC_WIDTH, 8, program counter and program memory address width.
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  pulse; begins execution at pc=0 when in IDLE or HALTED; ignored otherwise.
- imem_rd_en  out  1  program memory read strobe.
- imem_addr  out  PC_WIDTH  program memory address (= pc).
- imem_rdata  in  32  instruction word, valid the cycle after imem_rd_en.
- alu_opcode  out  16  ALU opcode ({select, op, 8'h00}).
- alu_a, alu_b  out  16 each  ALU operands.
- alu_c  in  16  ALU result, combinational from alu_opcode/alu_a/alu_b.
- alu_flags  in  4  ALU flags {O,N,C,Z}, combinational.
- flags_q  out  4  architectural flags register {O,N,C,Z}.
- pc  out  PC_WIDTH  current program counter.
- busy  out  1  high in FETCH, WAIT, EXEC.
- halted  out  1  high in HALTED.

## Operation
- Instruction word: [31:28] select, [27:24] op, [23:16] imm8, [11:8] rd, [7:4] ra, [3:0] rb; [15:12] ignored.
- select 0x0 NOP; 0x1 ALU (op passed to ALU, op values 0-8); 0x2 LOADI: rd <= {8'h00, imm8}; 0x3 BRANCH (see Configuration); 0xF HALT; any other select executes as NOP.
- States: IDLE -> (start) FETCH -> WAIT -> EXEC -> FETCH, or EXEC -> HALTED on HALT; HALTED -> (start) FETCH with pc=0.
- FETCH: imem_rd_en=1, imem_addr=pc. WAIT: latch imem_rdata into instruction register ir.
- EXEC: alu_opcode={ir[31:24],8'h00}, alu_a=rf[ra], alu_b=rf[rb] only when select==0x1, else all three 0. At the EXEC clock edge on ALU: rf[rd] <= alu_c, flags_q <= alu_flags. pc <= pc+1 unless a branch is taken.
- Only ALU instructions update flags_q; LOADI, NOP, BRANCH, HALT hold it.
- ra==rb or rd==ra permitted; operands are read before the writeback edge.
- pc wraps 255 -> 0 without fault.
- Register file: 16 entries, all writable, no hardwired zero.

## Timing
- 3 cycles per instruction (FETCH, WAIT, EXEC); first fetch in the cycle after start is sampled.
- Reset values: imem_rd_en 0, imem_addr 0, alu_opcode 0, alu_a 0, alu_b 0, flags_q 4'b0001, pc 0, busy 0, halted 0; all rf entries 0; state IDLE.
- Reset mid-instruction aborts with no writeback, no flags update and no pc change.
- start coincident with reset: reset wins.
- HALT: pc stays at the HALT address; halted asserts in the cycle after EXEC.

## Configuration
- SEQ_BRANCH_EN defined: select 0x3 is a conditional branch. If (flags_q & ir[27:24]) != 0, then pc <= imm8, else pc+1. op=4'b0000 is never taken. The branch tests flags_q as held before EXEC.
- SEQ_BRANCH_EN undefined: select 0x3 executes as NOP (pc+1, no state change).

## Test plan
- Reset: mid-EXEC async reset -> all outputs at reset values the same cycle; flags_q=0001; rf[rd] unchanged.
- LOADI r1=0x05, LOADI r2=0x03, ADD r3=r1+r2, HALT -> rf[3]=0x0008, flags_q=0000, halted at pc=3; 12 cycles start-to-halted.
- LOADI r1=0xFF, SHL r1 four times with rd=1, then ADD r4=r1+r1 with r1=0xFF00 -> rf[4]=0xFE00, C=1, N=1.
- SUB r5=r2-r2 with r2=3 -> rf[5]=0, flags_q=0001. Following LOADI keeps flags_q=0001.
- SEQ_BRANCH_EN: after a Z result, BRANCH op=0001 imm=0x10 -> next fetch at pc=0x10; with Z=0 -> pc+1. Without the macro -> always pc+1.
- pc wrap: NOP at 0xFF -> next imem_addr=0x00. start during busy is ignored; start in HALTED -> fetch from 0.

Source files
------------

// File: rtl/alu_sequencer_if.sv
// ============================================================================
// Module      : alu_sequencer_if
// Description : Program-memory and ALU bus bundle between the instruction
//               sequencer (master) and the memory/ALU side (slave).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface alu_sequencer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 8
);
   // Program memory: read strobe/address out, word back one cycle later
   logic                  imem_rd_en;
   logic [PC_WIDTH-1:0]   imem_addr;
   logic [31:0]           imem_rdata;

   // ALU: opcode/operands out, result and flags back combinationally
   logic [15:0]           alu_opcode;
   logic [DATA_WIDTH-1:0] alu_a;
   logic [DATA_WIDTH-1:0] alu_b;
   logic [DATA_WIDTH-1:0] alu_c;
   logic [3:0]            alu_flags;

   modport master (
      output imem_rd_en,
      output imem_addr,
      input  imem_rdata,
      output alu_opcode,
      output alu_a,
      output alu_b,
      input  alu_c,
      input  alu_flags
   );

   modport slave (
      input  imem_rd_en,
      input  imem_addr,
      output imem_rdata,
      input  alu_opcode,
      input  alu_a,
      input  alu_b,
      output alu_c,
      output alu_flags
   );
endinterface

`default_nettype wire

// File: rtl/alu_sequencer.sv
// ============================================================================
// Module      : alu_sequencer
// Description : Three-cycle (FETCH/WAIT/EXEC) instruction sequencer driving an
//               external combinational ALU. Holds a 16-entry register file,
//               the program counter and the architectural flags {O,N,C,Z}.
//               Optional feature macro: SEQ_BRANCH_EN (select 0x3 becomes a
//               conditional branch on flags_q; otherwise it is a NOP).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module alu_sequencer #(
   parameter int DATA_WIDTH = 16,
   parameter int PC_WIDTH   = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   alu_sequencer_if.master     bus,
   output logic [3:0]          flags_q,
   output logic [PC_WIDTH-1:0] pc,
   output logic                busy,
   output logic                halted
);

   // Instruction select field encodings
   localparam logic [3:0] c_sel_alu    = 4'h1;
   localparam logic [3:0] c_sel_loadi  = 4'h2;
   localparam logic [3:0] c_sel_branch = 4'h3;
   localparam logic [3:0] c_sel_halt   = 4'hF;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_WAIT   = 3'd2,
      S_EXEC   = 3'd3,
      S_HALTED = 3'd4
   } state_t;

   state_t                r_state;
   logic [PC_WIDTH-1:0]   r_pc;
   logic [3:0]            r_flags;
   logic                  r_rd_en;
   logic                  r_busy;
   logic                  r_halted;
   logic [15:0]           r_opcode;
   logic [DATA_WIDTH-1:0] r_alu_a;
   logic [DATA_WIDTH-1:0] r_alu_b;
   logic [DATA_WIDTH-1:0] r_rf [16];

   // Instruction register, kept as the fields EXEC actually consumes
   logic [3:0]            r_ir_sel;
   logic [3:0]            r_ir_op;
   logic [7:0]            r_ir_imm;
   logic [3:0]            r_ir_rd;

   // Decode of the word arriving from program memory during WAIT
   logic [3:0]            w_sel;
   logic [3:0]            w_op;
   logic [3:0]            w_ra;
   logic [3:0]            w_rb;
   logic                  w_unused_ir_bits;

   assign w_sel            = bus.imem_rdata[31:28];
   assign w_op             = bus.imem_rdata[27:24];
   assign w_ra             = bus.imem_rdata[7:4];
   assign w_rb             = bus.imem_rdata[3:0];
   assign w_unused_ir_bits = ^bus.imem_rdata[15:12];

   // Next-pc selection for the EXEC edge
   logic                  w_branch_taken;
   logic [PC_WIDTH-1:0]   w_pc_inc;
   logic [PC_WIDTH-1:0]   w_pc_next;

`ifdef SEQ_BRANCH_EN
   // Branch tests the flags as they stood before this EXEC; op=0 masks all
   assign w_branch_taken = (r_ir_sel == c_sel_branch) &&
                           ((r_flags & r_ir_op) != 4'b0000);
`else
   logic w_unused_branch_bits;
   assign w_unused_branch_bits = ^r_ir_op;
   assign w_branch_taken       = 1'b0;
`endif

   assign w_pc_inc  = r_pc + PC_WIDTH'(1);
   assign w_pc_next = w_branch_taken ? PC_WIDTH'(r_ir_imm) : w_pc_inc;

   // Sequencer state, register file, flags and all registered outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_pc     <= '0;
         r_flags  <= 4'b0001;
         r_rd_en  <= 1'b0;
         r_busy   <= 1'b0;
         r_halted <= 1'b0;
         r_opcode <= '0;
         r_alu_a  <= '0;
         r_alu_b  <= '0;
         r_ir_sel <= '0;
         r_ir_op  <= '0;
         r_ir_imm <= '0;
         r_ir_rd  <= '0;
         for (int i = 0; i < 16; i++) begin
            r_rf[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE, S_HALTED: begin
               if (start) begin
                  r_state  <= S_FETCH;
                  r_pc     <= '0;
                  r_rd_en  <= 1'b1;
                  r_busy   <= 1'b1;
                  r_halted <= 1'b0;
               end
            end

            S_FETCH: begin
               r_state <= S_WAIT;
               r_rd_en <= 1'b0;
            end

            S_WAIT: begin
               // Latch the instruction and present ALU operands for EXEC;
               // operands are read here, before any writeback of this word
               r_state  <= S_EXEC;
               r_ir_sel <= w_sel;
               r_ir_op  <= w_op;
               r_ir_imm <= bus.imem_rdata[23:16];
               r_ir_rd  <= bus.imem_rdata[11:8];
               if (w_sel == c_sel_alu) begin
                  r_opcode <= {w_sel, w_op, 8'h00};
                  r_alu_a  <= r_rf[w_ra];
                  r_alu_b  <= r_rf[w_rb];
               end else begin
                  r_opcode <= '0;
                  r_alu_a  <= '0;
                  r_alu_b  <= '0;
               end
            end

            S_EXEC: begin
               r_opcode <= '0;
               r_alu_a  <= '0;
               r_alu_b  <= '0;
               case (r_ir_sel)
                  c_sel_alu: begin
                     r_rf[r_ir_rd] <= bus.alu_c;
                     r_flags       <= bus.alu_flags;
                  end
                  c_sel_loadi: begin
                     r_rf[r_ir_rd] <= DATA_WIDTH'(r_ir_imm);
                  end
                  default: begin
                  end
               endcase
               if (r_ir_sel == c_sel_halt) begin
                  // pc stays on the HALT address
                  r_state  <= S_HALTED;
                  r_busy   <= 1'b0;
                  r_halted <= 1'b1;
               end else begin
                  r_state <= S_FETCH;
                  r_pc    <= w_pc_next;
                  r_rd_en <= 1'b1;
               end
            end

            default: begin
               r_state  <= S_IDLE;
               r_rd_en  <= 1'b0;
               r_busy   <= 1'b0;
               r_halted <= 1'b0;
            end
         endcase
      end
   end

   assign bus.imem_rd_en = r_rd_en;
   assign bus.imem_addr  = r_pc;
   assign bus.alu_opcode = r_opcode;
   assign bus.alu_a      = r_alu_a;
   assign bus.alu_b      = r_alu_b;
   assign flags_q        = r_flags;
   assign pc             = r_pc;
   assign busy           = r_busy;
   assign halted         = r_halted;

endmodule

`default_nettype wire

// File: tb/tb_alu_sequencer.sv
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. Supplies program memory
//               and a behavioural ALU, and compares the sequencer against an
//               instruction-level reference model (honours SEQ_BRANCH_EN).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_alu_sequencer;

   localparam int DW = 16;
   localparam int PW = 8;
   localparam logic [31:0] c_halt_word = 32'hF000_0000;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [3:0]    flags_q;
   logic [PW-1:0] pc;
   logic          busy;
   logic          halted;

   int            n_checks = 0;
   int            n_fail   = 0;

   logic [31:0]   imem [256];
   logic [15:0]   m_rf [16];
   logic [3:0]    m_flags;
   logic [7:0]    m_pc;
   logic [7:0]    exp_fetch [$];
   bit            mon_en = 1'b0;

   alu_sequencer_if #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) bus ();

   alu_sequencer #(.DATA_WIDTH(DW), .PC_WIDTH(PW)) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .bus     (bus),
      .flags_q (flags_q),
      .pc      (pc),
      .busy    (busy),
      .halted  (halted)
   );

   always #5 clk = ~clk;

   // Behavioural ALU: returns {O,N,C,Z, result}
   function automatic logic [19:0] alu_ref(input logic [3:0] op,
                                           input logic [15:0] a,
                                           input logic [15:0] b);
      logic [16:0] w;
      logic [15:0] r;
      logic        c;
      logic        o;
      c = 1'b0;
      o = 1'b0;
      r = '0;
      case (op)
         4'd0: begin
            w = {1'b0, a} + {1'b0, b};
            r = w[15:0];
            c = w[16];
            o = (a[15] == b[15]) && (r[15] != a[15]);
         end
         4'd1: begin
            r = a - b;
            c = (a < b);
            o = (a[15] != b[15]) && (r[15] != a[15]);
         end
         4'd2: r = a & b;
         4'd3: r = a | b;
         4'd4: r = a ^ b;
         4'd5: r = ~a;
         4'd6: r = a << b[3:0];
         4'd7: r = a >> b[3:0];
         4'd8: r = a;
         default: r = '0;
      endcase
      return {o, r[15], c, (r == 16'h0), r};
   endfunction

   always_comb begin
      {bus.alu_flags, bus.alu_c} = alu_ref(bus.alu_opcode[11:8], bus.alu_a, bus.alu_b);
   end

   // Synchronous program memory
   always @(posedge clk) begin
      if (bus.imem_rd_en) bus.imem_rdata <= imem[bus.imem_addr];
   end

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Every fetch must hit the next address the model predicted
   always @(negedge clk) begin
      if (mon_en && bus.imem_rd_en) begin
         logic [31:0] e;
         e = (exp_fetch.size() > 0) ? {24'h0, exp_fetch.pop_front()} : 32'hDEAD;
         check_val("fetch_addr", {24'h0, bus.imem_addr}, e);
         check_val("fetch_alu_idle", {16'h0, bus.alu_opcode}, 32'h0);
      end
   end

   function automatic logic [31:0] enc(input logic [3:0] sel, input logic [3:0] op,
                                       input logic [7:0] imm, input logic [3:0] rd,
                                       input logic [3:0] ra, input logic [3:0] rb);
      return {sel, op, imm, 4'h0, rd, ra, rb};
   endfunction

   task automatic clear_mem(input logic [31:0] fill);
      for (int i = 0; i < 256; i++) imem[i] = fill;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_rf[i] = '0;
      m_flags = 4'b0001;
   endtask

   // Instruction-level reference: executes the program image until HALT
   task automatic model_run(output int n);
      logic [7:0]  p;
      logic [31:0] w;
      logic [19:0] res;
      bit          done;
      p = '0;
      n = 0;
      done = 1'b0;
      exp_fetch.delete();
      while (!done && n < 1000) begin
         exp_fetch.push_back(p);
         w = imem[p];
         n++;
         case (w[31:28])
            4'h1: begin
               res = alu_ref(w[27:24], m_rf[w[7:4]], m_rf[w[3:0]]);
               m_rf[w[11:8]] = res[15:0];
               m_flags = res[19:16];
               p = p + 8'd1;
            end
            4'h2: begin
               m_rf[w[11:8]] = {8'h00, w[23:16]};
               p = p + 8'd1;
            end
`ifdef SEQ_BRANCH_EN
            4'h3: p = ((m_flags & w[27:24]) != 4'h0) ? w[23:16] : p + 8'd1;
`endif
            4'hF: done = 1'b1;
            default: p = p + 8'd1;
         endcase
      end
      m_pc = p;
   endtask

   task automatic run_prog(input string tag, input bit rand_start);
      int n_exp;
      int cycles;
      model_run(n_exp);
      mon_en = 1'b1;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cycles = 0;
      while (!halted && cycles < 3 * n_exp + 30) begin
         @(posedge clk);
         cycles++;
         #1;
         start = (rand_start && busy && !halted) ? ($urandom_range(0, 4) == 0) : 1'b0;
      end
      start = 1'b0;
      @(negedge clk);
      mon_en = 1'b0;
      check_val({tag, " cycles"}, cycles, 3 * n_exp);
      check_val({tag, " halted"}, {31'h0, halted}, 32'h1);
      check_val({tag, " pc"}, {24'h0, pc}, {24'h0, m_pc});
      check_val({tag, " flags"}, {28'h0, flags_q}, {28'h0, m_flags});
      check_val({tag, " fetch_left"}, exp_fetch.size(), 32'h0);
      for (int i = 0; i < 16; i++) begin
         check_val($sformatf("%s rf%0d", tag, i), {16'h0, dut.r_rf[i]}, {16'h0, m_rf[i]});
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, " rd_en"},  {31'h0, bus.imem_rd_en}, 32'h0);
      check_val({tag, " addr"},   {24'h0, bus.imem_addr}, 32'h0);
      check_val({tag, " opcode"}, {16'h0, bus.alu_opcode}, 32'h0);
      check_val({tag, " alu_a"},  {16'h0, bus.alu_a}, 32'h0);
      check_val({tag, " alu_b"},  {16'h0, bus.alu_b}, 32'h0);
      check_val({tag, " flags"},  {28'h0, flags_q}, 32'h1);
      check_val({tag, " pc"},     {24'h0, pc}, 32'h0);
      check_val({tag, " busy"},   {31'h0, busy}, 32'h0);
      check_val({tag, " halted"}, {31'h0, halted}, 32'h0);
   endtask

   initial begin
      int         cycles;
      int         len;
      int         k;
      logic [31:0] w;
      logic [7:0] after_ff;
      bit         prev_ff;

      reset = 1'b1;
      start = 1'b0;
      clear_mem(c_halt_word);
      repeat (2) @(negedge clk);
      #1 check_reset_outputs("rst");

      // start coincident with reset: reset wins
      start = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      start = 1'b0;
      @(negedge clk);
      check_val("rst_start busy", {31'h0, busy}, 32'h0);

      // Async reset in the middle of EXEC of NOT r4 = ~r0
      imem[0] = enc(4'h1, 4'd5, 8'h00, 4'd4, 4'd0, 4'd0);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check_val("exec opcode", {16'h0, bus.alu_opcode}, 32'h1500);
      reset = 1'b1;
      #1 check_reset_outputs("midexec");
      check_val("midexec rf4", {16'h0, dut.r_rf[4]}, 32'h0);
      @(negedge clk) reset = 1'b0;
      model_reset();

      // LOADI/LOADI/ADD/HALT
      clear_mem(c_halt_word);
      imem[0] = enc(4'h2, 4'd0, 8'h05, 4'd1, 4'd0, 4'd0);
      imem[1] = enc(4'h2, 4'd0, 8'h03, 4'd2, 4'd0, 4'd0);
      imem[2] = enc(4'h1, 4'd0, 8'h00, 4'd3, 4'd1, 4'd2);
      run_prog("progA", 1'b0);
      check_val("progA rf3", {16'h0, dut.r_rf[3]}, 32'h0008);
      check_val("progA flags", {28'h0, flags_q}, 32'h0);
      check_val("progA pc", {24'h0, pc}, 32'h3);

      // Shifts up to 0xFF00 then ADD with carry out
      clear_mem(c_halt_word);
      imem[0] = enc(4'h2, 4'd0, 8'hFF, 4'd1, 4'd0, 4'd0);
      imem[1] = enc(4'h2, 4'd0, 8'h02, 4'd2, 4'd0, 4'd0);
      for (int i = 2; i < 6; i++) imem[i] = enc(4'h1, 4'd6, 8'h00, 4'd1, 4'd1, 4'd2);
      imem[6] = enc(4'h1, 4'd0, 8'h00, 4'd4, 4'd1, 4'd1);
      run_prog("progB", 1'b0);
      check_val("progB rf4", {16'h0, dut.r_rf[4]}, 32'hFE00);
      check_val("progB flags", {28'h0, flags_q}, 32'h6);

      // SUB to zero, then LOADI must hold Z
      clear_mem(c_halt_word);
      imem[0] = enc(4'h2, 4'd0, 8'h03, 4'd2, 4'd0, 4'd0);
      imem[1] = enc(4'h1, 4'd1, 8'h00, 4'd5, 4'd2, 4'd2);
      imem[2] = enc(4'h2, 4'd0, 8'h44, 4'd6, 4'd0, 4'd0);
      run_prog("progC", 1'b0);
      check_val("progC rf5", {16'h0, dut.r_rf[5]}, 32'h0);
      check_val("progC flags", {28'h0, flags_q}, 32'h1);

      // Branch after Z=1: op=0 never taken, op=1 taken when enabled
      clear_mem(c_halt_word);
      imem[0] = enc(4'h2, 4'd0, 8'h03, 4'd2, 4'd0, 4'd0);
      imem[1] = enc(4'h1, 4'd1, 8'h00, 4'd5, 4'd2, 4'd2);
      imem[2] = enc(4'h3, 4'd0, 8'h30, 4'd0, 4'd0, 4'd0);
      imem[3] = enc(4'h3, 4'd1, 8'h10, 4'd0, 4'd0, 4'd0);
      run_prog("progD", 1'b0);
`ifdef SEQ_BRANCH_EN
      check_val("progD pc", {24'h0, pc}, 32'h10);
`else
      check_val("progD pc", {24'h0, pc}, 32'h4);
`endif

      // Branch with Z=0 falls through
      clear_mem(c_halt_word);
      imem[0] = enc(4'h2, 4'd0, 8'h03, 4'd2, 4'd0, 4'd0);
      imem[1] = enc(4'h1, 4'd0, 8'h00, 4'd5, 4'd2, 4'd2);
      imem[2] = enc(4'h3, 4'd1, 8'h10, 4'd0, 4'd0, 4'd0);
      run_prog("progE", 1'b0);
      check_val("progE pc", {24'h0, pc}, 32'h3);

      // pc wrap: NOPs everywhere, address 0 becomes HALT after its first fetch
      clear_mem(32'h0);
      after_ff = 8'hAA;
      prev_ff = 1'b0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      cycles = 0;
      while (!halted && cycles < 900) begin
         @(posedge clk);
         cycles++;
         #1;
         if (cycles == 3) imem[0] = c_halt_word;
         if (bus.imem_rd_en) begin
            if (prev_ff) after_ff = bus.imem_addr;
            prev_ff = (bus.imem_addr == 8'hFF);
         end
      end
      check_val("wrap cycles", cycles, 32'd771);
      check_val("wrap next_after_ff", {24'h0, after_ff}, 32'h0);
      check_val("wrap pc", {24'h0, pc}, 32'h0);

      // Randomized programs with forward-only branches, start pulses while busy
      for (int t = 0; t < 10; t++) begin
         len = $urandom_range(4, 24);
         clear_mem(c_halt_word);
         for (int i = 0; i < len - 1; i++) begin
            k = $urandom_range(0, 9);
            w = $urandom;
            case (k)
               0: w[31:28] = 4'h0;
               1: w[31:28] = 4'h7;
               2, 3, 4, 5: begin
                  w[31:28] = 4'h1;
                  w[27:24] = 4'($urandom_range(0, 8));
               end
               6, 7: w[31:28] = 4'h2;
               default: begin
                  w[31:28] = 4'h3;
                  w[23:16] = 8'($urandom_range(i + 1, len - 1));
               end
            endcase
            imem[i] = w;
         end
         imem[len - 1] = {4'hF, 28'($urandom)};
         run_prog($sformatf("rand%0d", t), 1'b1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
